// File: rtl/nand_sched_pkg.sv
// Shared types and helpers for the bit-serial NAND scheduler.
// Holds the FSM state enum, the statistics counter limits and the round-robin picker.
package nand_sched_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    localparam int          CNT_W   = 16;
    localparam logic [15:0] CNT_MAX = 16'hFFFF;
    localparam int          MAX_REQ = 8;

    // Returns the first set bit of valid_vec searching upward from last_grant+1,
    // wrapping modulo nreq. Falls back to last_grant when nothing is valid.
    function automatic int rr_pick(input logic [MAX_REQ-1:0] valid_vec,
                                   input int last_grant,
                                   input int nreq);
        int   pick;
        int   idx;
        logic found;
        pick  = last_grant;
        found = 1'b0;
        for (int i = 1; i <= MAX_REQ; i++) begin
            idx = (last_grant + i) % nreq;
            if (i <= nreq && !found && valid_vec[idx[2:0]]) begin
                pick  = idx;
                found = 1'b1;
            end
        end
        return pick;
    endfunction

endpackage

// File: rtl/nand_sched_bit.sv
// Shared 1-bit NAND evaluation unit; the scheduler instantiates it exactly once.
module nand_bit (
    input  logic a_i,
    input  logic b_i,
    output logic y_o
);

    assign y_o = ~(a_i & b_i);

endmodule

// File: rtl/nand_sched.sv
// Round-robin scheduler feeding NREQ operand pairs LSB-first through one shared NAND bit.
// Optional feature: define NAND_SCHED_STATS_EN to enable the saturating op_count register.
module nand_sched
    import nand_sched_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int W    = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NREQ-1:0]          req_valid,
    output logic [NREQ-1:0]          req_ready,
    input  logic [NREQ*W-1:0]        req_a,
    input  logic [NREQ*W-1:0]        req_b,
    output logic                     rsp_valid,
    input  logic                     rsp_ready,
    output logic [$clog2(NREQ)-1:0]  rsp_id,
    output logic [W-1:0]             rsp_data,
    output logic                     busy,
    output logic [15:0]              op_count
);

    localparam int ID_W = $clog2(NREQ);
    localparam int BC_W = $clog2(W);
    localparam logic [BC_W-1:0] BIT_LAST = BC_W'(W - 1);

    state_e            state_q;
    logic [ID_W-1:0]   last_grant_q;
    logic [ID_W-1:0]   rsp_id_q;
    logic [BC_W-1:0]   bit_cnt_q;
    logic [W-1:0]      a_sh_q;
    logic [W-1:0]      b_sh_q;
    logic [W-1:0]      res_sh_q;

    logic [MAX_REQ-1:0] valid_ext;
    logic [ID_W-1:0]    grant;
    logic               any_valid;
    logic               accept;
    logic               running;
    logic               rsp_hs;
    logic               nand_y;

    always_comb begin
        valid_ext = '0;
        valid_ext[NREQ-1:0] = req_valid;
        grant = ID_W'(rr_pick(valid_ext, int'(last_grant_q), NREQ));
    end

    assign any_valid = |req_valid;
    // Reset masks the grant so no requester sees a handshake that the FSM will ignore.
    assign accept    = (state_q == IDLE) && any_valid && !rst;
    assign running   = (state_q == RUN);
    assign rsp_hs    = (state_q == DONE) && rsp_ready;

    always_comb begin
        req_ready = '0;
        if (accept) begin
            req_ready[grant] = 1'b1;
        end
    end

    nand_bit u_nand_bit (
        .a_i (a_sh_q[0]),
        .b_i (b_sh_q[0]),
        .y_o (nand_y)
    );

    // Operand shifters carry pure data and need no reset.
    always_ff @(posedge clk) begin
        if (accept) begin
            a_sh_q <= req_a[int'(grant)*W +: W];
            b_sh_q <= req_b[int'(grant)*W +: W];
        end else if (running) begin
            a_sh_q <= a_sh_q >> 1;
            b_sh_q <= b_sh_q >> 1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            last_grant_q <= ID_W'(NREQ - 1);
            rsp_id_q     <= '0;
            res_sh_q     <= '0;
            bit_cnt_q    <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (any_valid) begin
                        rsp_id_q     <= grant;
                        last_grant_q <= grant;
                        bit_cnt_q    <= '0;
                        state_q      <= RUN;
                    end
                end
                RUN: begin
                    // Result enters at the MSB so the first evaluated bit lands in bit 0.
                    res_sh_q  <= {nand_y, res_sh_q[W-1:1]};
                    bit_cnt_q <= bit_cnt_q + 1'b1;
                    if (bit_cnt_q == BIT_LAST) begin
                        state_q <= DONE;
                    end
                end
                DONE: begin
                    if (rsp_ready) begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign rsp_valid = (state_q == DONE);
    assign busy      = (state_q != IDLE);
    assign rsp_id    = rsp_id_q;
    assign rsp_data  = res_sh_q;

`ifdef NAND_SCHED_STATS_EN
    logic [CNT_W-1:0] op_cnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            op_cnt_q <= '0;
        end else if (rsp_hs && op_cnt_q != CNT_MAX) begin
            op_cnt_q <= op_cnt_q + 1'b1;
        end
    end

    assign op_count = op_cnt_q;
`else
    logic unused_hs;
    assign unused_hs = rsp_hs;
    assign op_count  = 16'h0000;
`endif

endmodule

// File: tb/tb_nand_sched.sv
// Self-checking bench for nand_sched: directed scenarios plus randomized traffic
// compared against a round-robin / bitwise-NAND reference model.
module tb_nand_sched;

    localparam int NREQ = 4;
    localparam int W    = 8;
    localparam int ID_W = 2;

    logic                 clk = 1'b0;
    logic                 rst;
    logic [NREQ-1:0]      req_valid;
    logic [NREQ-1:0]      req_ready;
    logic [NREQ*W-1:0]    req_a;
    logic [NREQ*W-1:0]    req_b;
    logic                 rsp_valid;
    logic                 rsp_ready;
    logic [ID_W-1:0]      rsp_id;
    logic [W-1:0]         rsp_data;
    logic                 busy;
    logic [15:0]          op_count;

    int checks   = 0;
    int failures = 0;
    int model_last;
    logic [W-1:0] a_v [NREQ];
    logic [W-1:0] b_v [NREQ];

    nand_sched #(.NREQ(NREQ), .W(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_id    (rsp_id),
        .rsp_data  (rsp_data),
        .busy      (busy),
        .op_count  (op_count)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Reference model: plain modulo search for the next valid requester.
    function automatic int model_pick(input logic [NREQ-1:0] v);
        int c;
        for (int k = 1; k <= NREQ; k++) begin
            c = (model_last + k) % NREQ;
            if (v[c]) return c;
        end
        return -1;
    endfunction

    function automatic logic [W-1:0] model_nand(input logic [W-1:0] a, input logic [W-1:0] b);
        return ~(a & b);
    endfunction

    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    task automatic pack_ops();
        for (int i = 0; i < NREQ; i++) begin
            req_a[i*W +: W] = a_v[i];
            req_b[i*W +: W] = b_v[i];
        end
    endtask

    task automatic rand_ops();
        for (int i = 0; i < NREQ; i++) begin
            a_v[i] = W'($urandom);
            b_v[i] = W'($urandom);
        end
        pack_ops();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        req_valid = '0;
        cyc();
        rst = 1'b0;
        #1;
        model_last = NREQ - 1;
    endtask

    // Drives one full transaction with rsp_ready held high; reports what it saw.
    task automatic issue(input logic [NREQ-1:0] vmask, output logic [NREQ-1:0] rdy,
                         output int lat, output logic [W-1:0] data,
                         output logic [ID_W-1:0] id, output bit ok);
        ok = 1'b1; lat = 0; rdy = '0; data = '0; id = '0;
        rsp_ready = 1'b1;
        req_valid = vmask;
        #1;
        for (int n = 0; n < 20 && req_ready == '0; n++) cyc();
        if (req_ready == '0) begin
            ok = 1'b0;
            req_valid = '0;
            return;
        end
        rdy = req_ready;
        cyc();
        while (!rsp_valid && lat < 40) begin
            cyc();
            lat++;
        end
        if (!rsp_valid) ok = 1'b0;
        data = rsp_data;
        id   = rsp_id;
        cyc();
        req_valid = '0;
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        rsp_ready = 1'b1;
        req_valid = '1;
        rand_ops();
        cyc();
        cyc();
        #1;
        checks++; if (req_ready !== '0) begin failures++; $display("FAIL reset_req_ready got=%b exp=0000", req_ready); end
        checks++; if (rsp_valid !== 1'b0) begin failures++; $display("FAIL reset_rsp_valid got=%b exp=0", rsp_valid); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
        checks++; if (rsp_id !== '0) begin failures++; $display("FAIL reset_rsp_id got=%0d exp=0", rsp_id); end
        checks++; if (rsp_data !== '0) begin failures++; $display("FAIL reset_rsp_data got=%h exp=00", rsp_data); end
        checks++; if (op_count !== 16'h0) begin failures++; $display("FAIL reset_op_count got=%h exp=0000", op_count); end
        rst = 1'b0;
        #1;
        checks++; if (req_ready !== 4'b0001) begin failures++; $display("FAIL reset_first_priority got=%b exp=0001", req_ready); end
        req_valid = '0;
        #1;
        model_last = NREQ - 1;
    endtask

    task automatic test_single();
        logic [NREQ-1:0] rdy; int lat; logic [W-1:0] d; logic [ID_W-1:0] id; bit ok;
        rand_ops();
        a_v[2] = 8'hF0; b_v[2] = 8'hCC;
        pack_ops();
        issue(4'b0100, rdy, lat, d, id, ok);
        model_last = 2;
        checks++; if (ok !== 1'b1) begin failures++; $display("FAIL single_timeout got=%b exp=1", ok); end
        checks++; if (rdy !== 4'b0100) begin failures++; $display("FAIL single_ready got=%b exp=0100", rdy); end
        checks++; if (lat !== W) begin failures++; $display("FAIL single_latency got=%0d exp=%0d", lat, W); end
        checks++; if (id !== 2'd2) begin failures++; $display("FAIL single_id got=%0d exp=2", id); end
        checks++; if (d !== 8'h3F) begin failures++; $display("FAIL single_data got=%h exp=3f", d); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL single_idle_after got=%b exp=0", busy); end
    endtask

    task automatic test_round_robin();
        logic [NREQ-1:0] rdy; int lat; logic [W-1:0] d; logic [ID_W-1:0] id; bit ok;
        do_reset();
        for (int i = 0; i < NREQ; i++) begin
            a_v[i] = W'(8'h11 * (i + 1));
            b_v[i] = W'(8'hF3 - 8'h21 * i);
        end
        pack_ops();
        for (int i = 0; i < 6; i++) begin
            int g;
            g = i % NREQ;
            issue('1, rdy, lat, d, id, ok);
            model_last = g;
            checks++; if (ok !== 1'b1) begin failures++; $display("FAIL rr_timeout op=%0d got=%b exp=1", i, ok); end
            checks++; if (rdy !== NREQ'(1 << g)) begin failures++; $display("FAIL rr_grant op=%0d got=%b exp=%0d", i, rdy, g); end
            checks++; if (int'(id) !== g) begin failures++; $display("FAIL rr_id op=%0d got=%0d exp=%0d", i, id, g); end
            checks++; if (d !== model_nand(a_v[g], b_v[g])) begin failures++; $display("FAIL rr_data op=%0d got=%h exp=%h", i, d, model_nand(a_v[g], b_v[g])); end
        end
    endtask

    task automatic test_backpressure();
        logic [W-1:0] exp_d;
        int lat; int g2;
        rand_ops();
        exp_d = model_nand(a_v[1], b_v[1]);
        rsp_ready = 1'b0;
        req_valid = 4'b0010;
        #1;
        checks++; if (req_ready !== 4'b0010) begin failures++; $display("FAIL bp_accept got=%b exp=0010", req_ready); end
        cyc();
        model_last = 1;
        req_valid = 4'b1010;
        lat = 0;
        while (!rsp_valid && lat < 40) begin cyc(); lat++; end
        checks++; if (busy !== 1'b1) begin failures++; $display("FAIL bp_busy_done got=%b exp=1", busy); end
        for (int k = 0; k < 5; k++) begin
            checks++; if (rsp_valid !== 1'b1) begin failures++; $display("FAIL bp_valid cyc=%0d got=%b exp=1", k, rsp_valid); end
            checks++; if (rsp_data !== exp_d || rsp_id !== 2'd1) begin failures++; $display("FAIL bp_hold cyc=%0d got=%h/%0d exp=%h/1", k, rsp_data, rsp_id, exp_d); end
            checks++; if (req_ready !== '0 || busy !== 1'b1) begin failures++; $display("FAIL bp_blocked cyc=%0d got=%b/%b exp=0000/1", k, req_ready, busy); end
            cyc();
        end
        rsp_ready = 1'b1;
        #1;
        cyc();
        g2 = model_pick(4'b1010);
        checks++; if (req_ready !== NREQ'(1 << g2)) begin failures++; $display("FAIL bp_next_accept got=%b exp=%0d", req_ready, g2); end
        checks++; if (rsp_valid !== 1'b0) begin failures++; $display("FAIL bp_released got=%b exp=0", rsp_valid); end
        cyc();
        model_last = g2;
        req_valid = '0;
        lat = 0;
        while (!rsp_valid && lat < 40) begin cyc(); lat++; end
        checks++; if (rsp_data !== model_nand(a_v[g2], b_v[g2]) || int'(rsp_id) !== g2) begin failures++; $display("FAIL bp_second got=%h/%0d exp=%h/%0d", rsp_data, rsp_id, model_nand(a_v[g2], b_v[g2]), g2); end
        cyc();
    endtask

    task automatic test_reset_mid_run();
        logic [NREQ-1:0] rdy; int lat; logic [W-1:0] d; logic [ID_W-1:0] id; bit ok;
        rand_ops();
        rsp_ready = 1'b1;
        req_valid = 4'b0010;
        #1;
        cyc();
        req_valid = '0;
        cyc(); cyc(); cyc();
        rst = 1'b1;
        req_valid = '1;
        #1;
        checks++; if (req_ready !== '0) begin failures++; $display("FAIL midrst_ready got=%b exp=0000", req_ready); end
        cyc();
        rst = 1'b0;
        req_valid = '0;
        #1;
        model_last = NREQ - 1;
        checks++; if (rsp_valid !== 1'b0 || busy !== 1'b0) begin failures++; $display("FAIL midrst_state got=%b/%b exp=0/0", rsp_valid, busy); end
        for (int k = 0; k < W + 2; k++) begin
            cyc();
            if (rsp_valid !== 1'b0) break;
        end
        checks++; if (rsp_valid !== 1'b0) begin failures++; $display("FAIL midrst_no_rsp got=%b exp=0", rsp_valid); end
        a_v[3] = 8'hFF; b_v[3] = 8'hFF;
        pack_ops();
        issue(4'b1000, rdy, lat, d, id, ok);
        model_last = 3;
        checks++; if (ok !== 1'b1 || rdy !== 4'b1000) begin failures++; $display("FAIL midrst_req3_grant got=%b exp=1000", rdy); end
        checks++; if (id !== 2'd3 || d !== 8'h00) begin failures++; $display("FAIL midrst_req3 got=%0d/%h exp=3/00", id, d); end
    endtask

    task automatic test_boundaries();
        logic [NREQ-1:0] rdy; int lat; logic [W-1:0] d; logic [ID_W-1:0] id; bit ok;
        logic [W-1:0] ta [3];
        logic [W-1:0] tb [3];
        logic [W-1:0] te [3];
        ta = '{8'h00, 8'hAA, 8'hFF};
        tb = '{8'h00, 8'h55, 8'h0F};
        te = '{8'hFF, 8'hFF, 8'hF0};
        for (int i = 0; i < 3; i++) begin
            rand_ops();
            a_v[0] = ta[i]; b_v[0] = tb[i];
            pack_ops();
            issue(4'b0001, rdy, lat, d, id, ok);
            model_last = 0;
            checks++; if (ok !== 1'b1 || id !== 2'd0 || d !== te[i]) begin failures++; $display("FAIL boundary_%0d got=%h id=%0d exp=%h id=0", i, d, id, te[i]); end
        end
    endtask

    task automatic test_random();
        logic [NREQ-1:0] rdy; int lat; logic [W-1:0] d; logic [ID_W-1:0] id; bit ok;
        logic [NREQ-1:0] m;
        int g;
        for (int i = 0; i < 24; i++) begin
            rand_ops();
            m = NREQ'($urandom_range(1, (1 << NREQ) - 1));
            g = model_pick(m);
            issue(m, rdy, lat, d, id, ok);
            model_last = g;
            checks++; if (ok !== 1'b1 || rdy !== NREQ'(1 << g) || int'(id) !== g) begin failures++; $display("FAIL rand_grant op=%0d mask=%b got=%b id=%0d exp=%0d", i, m, rdy, id, g); end
            checks++; if (d !== model_nand(a_v[g], b_v[g]) || lat !== W) begin failures++; $display("FAIL rand_data op=%0d got=%h lat=%0d exp=%h lat=%0d", i, d, lat, model_nand(a_v[g], b_v[g]), W); end
        end
    endtask

    task automatic test_stats();
        logic [NREQ-1:0] rdy; int lat; logic [W-1:0] d; logic [ID_W-1:0] id; bit ok;
`ifdef NAND_SCHED_STATS_EN
        do_reset();
        for (int i = 0; i < 3; i++) begin
            rand_ops();
            issue(4'b0100, rdy, lat, d, id, ok);
        end
        model_last = 2;
        checks++; if (op_count !== 16'd3) begin failures++; $display("FAIL stats_count got=%0d exp=3", op_count); end
        force dut.op_cnt_q = 16'hFFFF;
        cyc();
        release dut.op_cnt_q;
        issue(4'b0100, rdy, lat, d, id, ok);
        checks++; if (op_count !== 16'hFFFF) begin failures++; $display("FAIL stats_saturate got=%h exp=ffff", op_count); end
`else
        rand_ops();
        issue(4'b0001, rdy, lat, d, id, ok);
        model_last = 0;
        checks++; if (op_count !== 16'h0000) begin failures++; $display("FAIL stats_disabled got=%h exp=0000", op_count); end
`endif
    endtask

    initial begin
        rst = 1'b1;
        req_valid = '0;
        rsp_ready = 1'b1;
        req_a = '0;
        req_b = '0;
        model_last = NREQ - 1;
        test_reset();
        test_single();
        test_round_robin();
        test_backpressure();
        test_reset_mid_run();
        test_boundaries();
        test_random();
        test_stats();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/nand_sched.md
# nand_sched

Bit-serial scheduler that shares one 1-bit NAND evaluation unit among NREQ requesters. Each requester presents a W-bit operand pair through a valid/ready handshake. The block grants requesters in round-robin order and feeds one bit per cycle, LSB first, through the shared NAND. It returns the W-bit result tagged with the requester ID on a single valid/ready response channel. It sits between the user-facing input/output mapping of the Tiny Tapeout tile and the NAND datapath.

## Interface
Parameters:
- NREQ, 4: number of requesters (2..8).
- W, 8: operand/result width (2..16).

Ports (one clock; reset is synchronous and active-high):
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  NREQ  request valid, one bit per requester.
- req_ready  out  NREQ  request accepted this cycle (one-hot or zero).
- req_a  in  NREQ*W  operand A; requester i occupies bits [i*W +: W].
- req_b  in  NREQ*W  operand B; same packing as req_a.
- rsp_valid  out  1  result available.
- rsp_ready  in  1  result consumed.
- rsp_id  out  $clog2(NREQ)  index of the requester that owns the result.
- rsp_data  out  W  bitwise NAND of the captured A and B.
- busy  out  1  high in RUN or DONE.
- op_count  out  16  completed-operation count (see Configuration).

## Operation
- FSM states: IDLE, RUN, DONE.
- **IDLE**
  - If any req_valid is high, grant the first valid requester found by searching upward from last_grant+1, wrapping modulo NREQ.
  - req_ready[g] is high combinationally in the same cycle; all other req_ready bits stay 0.
  - On that edge: capture a_sh = req_a[g], b_sh = req_b[g], rsp_id = g, last_grant = g, bit_cnt = 0; go to RUN.
- **RUN**
  - Each cycle, nand_bit evaluates ~(a_sh[0] & b_sh[0]).
  - The result bit shifts into res_sh from the MSB side; a_sh and b_sh shift right.
  - bit_cnt increments each cycle. When bit_cnt == W-1, go to DONE; rsp_data then holds the full result, with bit 0 as the first bit evaluated.
- **DONE**
  - rsp_valid = 1.
  - rsp_data and rsp_id stay stable until rsp_valid && rsp_ready, then go to IDLE.
  - No new request is accepted while in RUN or DONE; req_ready is all 0.
- req_valid is sampled only in IDLE. A requester may drop valid without penalty while it is not granted.
- Reset values (reset has priority over every transition):
  - state = IDLE, last_grant = NREQ-1, so requester 0 has first priority.
  - rsp_valid = 0, rsp_id = 0, rsp_data = 0, busy = 0, op_count = 0.
  - req_ready = 0 during any cycle in which rst is high.
- Reset during RUN or DONE discards the in-flight operation; no response is issued for it.

## Timing
- Accept on edge t (IDLE, req_valid[g] && req_ready[g]).
- RUN occupies cycles t+1 .. t+W.
- rsp_valid rises in cycle t+W+1.
- Minimum issue interval is W+2 cycles: accept, then W RUN cycles, then one DONE cycle with rsp_ready high. IDLE may accept in the cycle immediately after the response handshake.
- Response backpressure holds the FSM in DONE indefinitely, with busy = 1.
- Fairness: with all requesters continuously valid, each is granted exactly once per NREQ operations.

## Configuration
- NAND_SCHED_STATS_EN defined:
  - op_count increments by 1 on each response handshake (rsp_valid && rsp_ready).
  - It saturates at 16'hFFFF and clears only on rst.
- Not defined: op_count is tied to 16'h0000 and no counter register is synthesised.

## Structure
- Package nand_sched_pkg holds:
  - the state enum (IDLE, RUN, DONE);
  - CNT_W = 16 and CNT_MAX = 16'hFFFF;
  - a function rr_pick(valid_vec, last_grant) returning the next grant index.
- One sub-module, nand_bit: a combinational 1-bit NAND, y = ~(a & b). It is the shared resource, instantiated exactly once.
- The top level contains the FSM, the shift registers, bit_cnt, the round-robin pointer and the optional counter.

## Test plan
- Single request: NREQ=4, W=8; req 2 valid with A=0xF0, B=0xCC, rsp_ready=1 → req_ready=4'b0100 for one cycle; rsp_valid 9 cycles after accept; rsp_id=2, rsp_data=0x3F.
- Round-robin: all 4 requesters held valid with distinct operands → grant order 0,1,2,3,0,1; each rsp_data matches the NAND of its own operands.
- Backpressure: hold rsp_ready=0 for 5 cycles in DONE → rsp_valid, rsp_id and rsp_data stable; req_ready=0; busy=1. One cycle after rsp_ready rises, the next request is accepted.
- Reset mid-RUN: assert rst at bit 3 of an operation from req 1 → next cycle rsp_valid=0, busy=0. A later lone request from req 3 with A=0xFF, B=0xFF yields rsp_id=3, rsp_data=0x00.
- Boundaries: A=0x00, B=0x00 → 0xFF; A=0xAA, B=0x55 → 0xFF; A=0xFF, B=0x0F → 0xF0.
- Stats: with NAND_SCHED_STATS_EN, 3 completed operations → op_count=3; with op_count forced to 0xFFFF, one further operation leaves 0xFFFF. Without the macro, op_count=0 throughout.
